// File: rtl/nn_classify_sequencer_pkg.sv
// Shared constants and types for the classify sequencer.
// Words are Q6.10 signed; three samples travel together per beat.
package nn_classify_sequencer_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 10;
    localparam int N_FEAT     = 9;
    localparam int TIMEOUT    = 64;
    localparam int ADDR_W     = 4;
    localparam int BIAS_ADDR  = 9;

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef struct packed {
        word_t x1;
        word_t x2;
        word_t x3;
    } beat_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CLEAR  = 3'd2,
        STREAM = 3'd3,
        WAIT   = 3'd4,
        HOLD   = 3'd5
    } state_t;

endpackage

// File: rtl/nn_classify_sequencer_if.sv
// Config, feature, datapath and result signals of the sequencer.
// slave is the sequencer side, master the surrounding system.
interface nn_classify_sequencer_if;
    import nn_classify_sequencer_pkg::*;

    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    word_t             cfg_wdata;
    logic              cfg_busy;

    logic              in_valid;
    logic              in_ready;
    word_t             in_x1;
    word_t             in_x2;
    word_t             in_x3;

    logic              dp_start;
    logic              dp_clr;
    word_t             dp_x1j;
    word_t             dp_x2j;
    word_t             dp_x3j;
    word_t             dp_wj;
    word_t             dp_b1;
    logic              dp_done;
    logic              dp_unhealthy;

    logic              res_valid;
    logic              res_ready;
    logic              res_unhealthy;
    logic              res_timeout;
    logic [15:0]       unhealthy_cnt;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata,
        output in_valid, in_x1, in_x2, in_x3,
        output dp_done, dp_unhealthy, res_ready,
        input  cfg_busy, in_ready,
        input  dp_start, dp_clr,
        input  dp_x1j, dp_x2j, dp_x3j, dp_wj, dp_b1,
        input  res_valid, res_unhealthy, res_timeout,
        input  unhealthy_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata,
        input  in_valid, in_x1, in_x2, in_x3,
        input  dp_done, dp_unhealthy, res_ready,
        output cfg_busy, in_ready,
        output dp_start, dp_clr,
        output dp_x1j, dp_x2j, dp_x3j, dp_wj, dp_b1,
        output res_valid, res_unhealthy, res_timeout,
        output unhealthy_cnt
    );

endinterface

// File: rtl/nn_feature_buffer.sv
// Register file holding one sample set (three 16-bit elements per index).
// Reads are combinational; out-of-range reads return zero.
module nn_feature_buffer
    import nn_classify_sequencer_pkg::*;
#(
    parameter int DEPTH = N_FEAT,
    parameter int IDX_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  beat_t            wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output beat_t            rdata_o
);

    beat_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i < IDX_W'(DEPTH))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (raddr_i < IDX_W'(DEPTH)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/nn_classify_sequencer.sv
// Collects a sample set, streams it with the weights into the datapath,
// then waits for a decision (or times out) and holds the result.
module nn_classify_sequencer #(
    parameter int DATA_WIDTH = nn_classify_sequencer_pkg::DATA_WIDTH,
    parameter int N_FEAT     = nn_classify_sequencer_pkg::N_FEAT,
    parameter int TIMEOUT    = nn_classify_sequencer_pkg::TIMEOUT
) (
    input logic                    clk,
    input logic                    rst,
    nn_classify_sequencer_if.slave bus
);
    import nn_classify_sequencer_pkg::*;

    localparam int IDX_W = $clog2(N_FEAT + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef logic [DATA_WIDTH-1:0] dword_t;

    state_t           state_q;
    logic [IDX_W-1:0] j_q;
    logic [IDX_W-1:0] k_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    dword_t           w_q [N_FEAT];
    dword_t           b1_q;

    logic             in_ready_q;
    logic             cfg_busy_q;
    logic             dp_start_q;
    logic             dp_clr_q;
    dword_t           dp_x1_q;
    dword_t           dp_x2_q;
    dword_t           dp_x3_q;
    dword_t           dp_w_q;
    dword_t           dp_b1_q;
    logic             res_valid_q;
    logic             res_unh_q;
    logic             res_to_q;
    logic [15:0]      ucnt_q;
    logic [15:0]      ucnt_d;

    logic             accept;
    logic             last_beat;
    beat_t            rd_beat;

    // in_ready_q is only high in IDLE/LOAD, so accept implies a store
    assign accept    = bus.in_valid & in_ready_q;
    assign last_beat = (j_q == IDX_W'(N_FEAT - 1));
    assign cnt_d     = cnt_q + 1'b1;
    assign ucnt_d    = (res_unh_q && (ucnt_q != 16'hFFFF)) ?
                       ucnt_q + 16'd1 : ucnt_q;

    nn_feature_buffer #(
        .DEPTH (N_FEAT),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk_i   (clk),
        .rst_ni  (rst),
        .we_i    (accept),
        .waddr_i (j_q),
        .wdata_i ({bus.in_x1, bus.in_x2, bus.in_x3}),
        .raddr_i (k_q),
        .rdata_o (rd_beat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            j_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < N_FEAT; i++) begin
                w_q[i] <= '0;
            end
            b1_q        <= '0;
            in_ready_q  <= 1'b1;
            cfg_busy_q  <= 1'b0;
            dp_start_q  <= 1'b0;
            dp_clr_q    <= 1'b0;
            dp_x1_q     <= '0;
            dp_x2_q     <= '0;
            dp_x3_q     <= '0;
            dp_w_q      <= '0;
            dp_b1_q     <= '0;
            res_valid_q <= 1'b0;
            res_unh_q   <= 1'b0;
            res_to_q    <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            dp_clr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cfg_we) begin
                        if (bus.cfg_addr < ADDR_W'(N_FEAT)) begin
                            w_q[bus.cfg_addr] <= bus.cfg_wdata;
                        end else if (bus.cfg_addr == ADDR_W'(BIAS_ADDR)) begin
                            b1_q <= bus.cfg_wdata;
                        end
                    end
                    if (accept) begin
                        cfg_busy_q <= 1'b1;
                        if (N_FEAT == 1) begin
                            state_q    <= CLEAR;
                            in_ready_q <= 1'b0;
                            dp_clr_q   <= 1'b1;
                            k_q        <= '0;
                        end else begin
                            state_q <= LOAD;
                            j_q     <= IDX_W'(1);
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (last_beat) begin
                            state_q    <= CLEAR;
                            j_q        <= '0;
                            in_ready_q <= 1'b0;
                            dp_clr_q   <= 1'b1;
                            k_q        <= '0;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end
                end
                // CLEAR presents element 0; STREAM presents the rest back-to-back
                CLEAR, STREAM: begin
                    dp_start_q <= 1'b1;
                    dp_b1_q    <= b1_q;
                    if ((state_q == STREAM) && (k_q == IDX_W'(N_FEAT))) begin
                        state_q <= WAIT;
                        dp_x1_q <= '0;
                        dp_x2_q <= '0;
                        dp_x3_q <= '0;
                        dp_w_q  <= '0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= STREAM;
                        dp_x1_q <= rd_beat.x1;
                        dp_x2_q <= rd_beat.x2;
                        dp_x3_q <= rd_beat.x3;
                        dp_w_q  <= w_q[k_q];
                        k_q     <= k_q + 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (bus.dp_done) begin
                        state_q     <= HOLD;
                        res_valid_q <= 1'b1;
                        res_unh_q   <= bus.dp_unhealthy;
                        res_to_q    <= 1'b0;
                    end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_q     <= HOLD;
                        res_valid_q <= 1'b1;
                        res_unh_q   <= 1'b0;
                        res_to_q    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        state_q     <= IDLE;
                        ucnt_q      <= ucnt_d;
                        res_valid_q <= 1'b0;
                        res_unh_q   <= 1'b0;
                        res_to_q    <= 1'b0;
                        dp_start_q  <= 1'b0;
                        dp_b1_q     <= '0;
                        cfg_busy_q  <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_busy      = cfg_busy_q;
    assign bus.in_ready      = in_ready_q;
    assign bus.dp_start      = dp_start_q;
    assign bus.dp_clr        = dp_clr_q;
    assign bus.dp_x1j        = dp_x1_q;
    assign bus.dp_x2j        = dp_x2_q;
    assign bus.dp_x3j        = dp_x3_q;
    assign bus.dp_wj         = dp_w_q;
    assign bus.dp_b1         = dp_b1_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_unhealthy = res_unh_q;
    assign bus.res_timeout   = res_to_q;
    assign bus.unhealthy_cnt = ucnt_q;

endmodule

// File: tb/tb_nn_classify_sequencer.sv
// Directed plus randomized checks of the classify sequencer against
// a sample-level model (weights, beat list, result counter).
module tb_nn_classify_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;

    logic [15:0] mw [9];
    logic [15:0] mb1;
    logic [47:0] beats [9];
    int          mucnt;

    nn_classify_sequencer_if bus ();

    nn_classify_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        tick();
        bus.cfg_we    = 1'b0;
        if (a < 4'd9) mw[a] = d;
        else if (a == 4'd9) mb1 = d;
    endtask

    task automatic load_random_weights();
        for (int a = 0; a < 10; a++) begin
            cfg_write(4'(a), 16'($urandom));
        end
        cfg_write(4'($urandom_range(15, 10)), 16'($urandom));
    endtask

    task automatic random_beats();
        for (int j = 0; j < 9; j++) begin
            beats[j] = {16'($urandom), 16'($urandom), 16'($urandom)};
        end
    endtask

    task automatic send_beats(input bit gaps, input bit noise);
        bus.dp_done      = noise;
        bus.dp_unhealthy = noise;
        for (int j = 0; j < 9; j++) begin
            if (gaps && j > 0) begin
                bus.in_valid = 1'b0;
                bus.in_x1    = 16'hDEAD;
                tick();
            end
            check("in_ready_load", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b1;
            {bus.in_x1, bus.in_x2, bus.in_x3} = beats[j];
            tick();
        end
        bus.in_valid = 1'b0;
        check("clear_cycle",
              {60'd0, bus.dp_clr, bus.in_ready, bus.cfg_busy, bus.dp_start},
              64'b1010);
    endtask

    task automatic stream_check(input int nk);
        for (int k = 0; k < nk; k++) begin
            tick();
            check("stream_ctl", {62'd0, bus.dp_clr, bus.dp_start}, 64'b01);
            check($sformatf("dp_x[%0d]", k),
                  {16'd0, bus.dp_x1j, bus.dp_x2j, bus.dp_x3j},
                  {16'd0, beats[k]});
            check($sformatf("dp_w[%0d]", k),
                  {32'd0, bus.dp_wj, bus.dp_b1}, {32'd0, mw[k], mb1});
        end
        bus.dp_done      = 1'b0;
        bus.dp_unhealthy = 1'b0;
    endtask

    // done_at = WAIT cycle carrying dp_done (0 = never)
    task automatic wait_and_hold(input int done_at, input bit unh,
                                 input int hold, input bit wcfg);
        bit to;
        bit exp_unh;
        tick();
        check("wait_ops", {bus.dp_start, bus.dp_x1j, bus.dp_x2j,
                           bus.dp_x3j, bus.dp_wj[14:0]}, 64'h8000_0000_0000_0000);
        for (int c = 1; c <= 64; c++) begin
            if (c == 1 || c == done_at || c == 64)
                check("wait_no_result", 64'(bus.res_valid), 64'd0);
            bus.cfg_we       = wcfg && (c == 5);
            bus.cfg_addr     = 4'd0;
            bus.cfg_wdata    = 16'h7777;
            bus.dp_done      = (c == done_at);
            bus.dp_unhealthy = unh;
            tick();
            bus.cfg_we  = 1'b0;
            bus.dp_done = 1'b0;
            if (c == done_at) break;
        end
        to      = (done_at == 0);
        exp_unh = to ? 1'b0 : unh;
        for (int h = 0; h <= hold; h++) begin
            check("res_valid", 64'(bus.res_valid), 64'd1);
            check("res_flags", {62'd0, bus.res_unhealthy, bus.res_timeout},
                  {62'd0, exp_unh, to});
            check("ucnt_hold", 64'(bus.unhealthy_cnt), 64'(mucnt));
            bus.res_ready = (h == hold);
            tick();
        end
        bus.res_ready = 1'b0;
        if (exp_unh && mucnt < 65535) mucnt++;
        check("after_hs", {60'd0, bus.res_valid, bus.dp_start,
                           bus.cfg_busy, bus.in_ready}, 64'b0001);
        check("ucnt", 64'(bus.unhealthy_cnt), 64'(mucnt));
    endtask

    initial begin
        bus.cfg_we       = 1'b0;
        bus.cfg_addr     = '0;
        bus.cfg_wdata    = '0;
        bus.in_valid     = 1'b0;
        bus.in_x1        = '0;
        bus.in_x2        = '0;
        bus.in_x3        = '0;
        bus.dp_done      = 1'b0;
        bus.dp_unhealthy = 1'b0;
        bus.res_ready    = 1'b0;
        for (int i = 0; i < 9; i++) mw[i] = '0;
        mb1   = '0;
        mucnt = 0;

        rst = 1'b0;
        repeat (3) tick();
        check("rst_ctl", {58'd0, bus.cfg_busy, bus.in_ready, bus.dp_start,
                          bus.dp_clr, bus.res_valid, bus.res_timeout},
              64'b010000);
        check("rst_ops", {bus.dp_x1j, bus.dp_x2j, bus.dp_wj, bus.dp_b1}, 64'd0);
        check("rst_ucnt", {47'd0, bus.res_unhealthy, bus.unhealthy_cnt}, 64'd0);
        rst = 1'b1;
        tick();

        // fixed weights, zero sample, quick healthy result
        cfg_write(4'd0, 16'h034C);
        cfg_write(4'd1, 16'h064F);
        cfg_write(4'd2, 16'h067D);
        cfg_write(4'd3, 16'h048A);
        cfg_write(4'd4, 16'h044F);
        cfg_write(4'd5, 16'h03C9);
        cfg_write(4'd6, 16'h0563);
        cfg_write(4'd7, 16'h04BA);
        cfg_write(4'd8, 16'h069D);
        cfg_write(4'd9, 16'hF3A3);
        for (int j = 0; j < 9; j++) beats[j] = '0;
        send_beats(1'b0, 1'b0);
        stream_check(9);
        wait_and_hold(3, 1'b0, 0, 1'b0);

        // gapped input, ordered x1 = j+1, unhealthy after 12, slow consumer
        for (int j = 0; j < 9; j++)
            beats[j] = {16'(j + 1), 16'($urandom), 16'($urandom)};
        send_beats(1'b1, 1'b0);
        stream_check(9);
        wait_and_hold(12, 1'b1, 5, 1'b0);

        // random weights, spurious dp_done early, timeout, cfg during WAIT
        load_random_weights();
        random_beats();
        send_beats(1'b0, 1'b1);
        stream_check(9);
        wait_and_hold(0, 1'b1, 2, 1'b1);
        random_beats();
        send_beats(1'b0, 1'b0);
        stream_check(9);
        wait_and_hold(2, 1'b0, 1, 1'b0);

        // reset in the middle of streaming
        random_beats();
        send_beats(1'b0, 1'b0);
        stream_check(4);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_ctl", {60'd0, bus.dp_start, bus.in_ready,
                             bus.cfg_busy, bus.dp_clr}, 64'b0100);
        check("midrst_ucnt", 64'(bus.unhealthy_cnt), 64'd0);
        for (int i = 0; i < 9; i++) mw[i] = '0;
        mb1   = '0;
        mucnt = 0;
        random_beats();
        send_beats(1'b0, 1'b0);
        stream_check(9);
        wait_and_hold(7, 1'b1, 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            load_random_weights();
            random_beats();
            send_beats(1'($urandom), 1'($urandom));
            stream_check(9);
            wait_and_hold(int'($urandom_range(20, 1)), 1'($urandom),
                          int'($urandom_range(3, 0)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
